// File: rtl/l1d_load_hit_checker_pkg.sv
// l1d_load_hit_checker_pkg: shared request/response types, cache geometry and refill states
package l1d_load_hit_checker_pkg;
  localparam int XLEN_WIDTH = 32;
  localparam int L1D_SETS = 64;
  localparam int L1D_LINE_BYTES = 16;
  typedef struct packed {
    logic        load_req;
    logic        load_kill;
    logic [31:0] load_addr;
  } core_load_ck_hit_req_t;
  typedef struct packed {
    logic load_hit;
    logic load_miss;
  } core_load_hit_resp_t;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, FILL} l1d_refill_state_e;
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/l1d_tag_array.sv
// l1d_tag_array: 2-way tag/valid/LRU store with combinational lookup and one fill port
module l1d_tag_array #(
  parameter int SETS  = 64,
  parameter int TAG_W = 22
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [$clog2(SETS)-1:0] rd_idx,
  input  logic [TAG_W-1:0]        rd_tag,
  output logic                    hit,
  output logic                    hit_way,
  output logic                    victim_way,
  input  logic                    lru_en,
  input  logic                    lru_way,
  input  logic                    inv_all,
  input  logic                    wr_en,
  input  logic [$clog2(SETS)-1:0] wr_idx,
  input  logic                    wr_way,
  input  logic [TAG_W-1:0]        wr_tag
);
  logic [TAG_W-1:0] tag0 [SETS];
  logic [TAG_W-1:0] tag1 [SETS];
  logic [SETS-1:0] vld0, vld1, lru;
  logic h0, h1;
  // lookup and victim choice: invalid way 0, then invalid way 1, then the LRU way
  always_comb begin
    h0 = vld0[rd_idx] && tag0[rd_idx] == rd_tag;
    h1 = vld1[rd_idx] && tag1[rd_idx] == rd_tag;
    hit = h0 || h1;
    hit_way = !h0;
    victim_way = !vld0[rd_idx] ? 1'b0 : !vld1[rd_idx] ? 1'b1 : lru[rd_idx];
  end
  // valid/LRU state; a fill overrides a same-set hit update, invalidate clears last
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vld0 <= '0;
      vld1 <= '0;
      lru <= '0;
    end else begin
      if (lru_en) lru[rd_idx] <= !lru_way;
      if (wr_en) lru[wr_idx] <= !wr_way;
      if (wr_en && !wr_way) vld0[wr_idx] <= 1'b1;
      if (wr_en && wr_way) vld1[wr_idx] <= 1'b1;
      if (inv_all) begin
        vld0 <= '0;
        vld1 <= '0;
      end
    end
  // tag storage needs no reset: valid bits qualify every compare
  always_ff @(posedge clk)
    if (wr_en) begin
      if (wr_way) tag1[wr_idx] <= wr_tag;
      else tag0[wr_idx] <= wr_tag;
    end
endmodule

// File: rtl/l1d_load_hit_checker.sv
// l1d_load_hit_checker: load hit check with 2-way LRU tags and miss refill handshake (optional LOAD_HIT_PERF_CNT_EN)
module l1d_load_hit_checker
  import l1d_load_hit_checker_pkg::*;
#(
  parameter int SETS       = L1D_SETS,
  parameter int LINE_BYTES = L1D_LINE_BYTES,
  parameter int TAG_W      = XLEN_WIDTH - $clog2(SETS) - $clog2(LINE_BYTES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  core_load_ck_hit_req_t load_ck_hit_req,
  output core_load_hit_resp_t   load_hit_resp,
  output logic                  load_hit_way,
  output logic                  refill_req_valid,
  input  logic                  refill_req_ready,
  output logic [31:0]           refill_req_addr,
  output logic                  refill_req_way,
  input  logic                  refill_done,
  input  logic                  invalidate_all,
  output logic [31:0]           perf_hit_cnt,
  output logic [31:0]           perf_miss_cnt
);
  localparam int IDX_W = $clog2(SETS);
  localparam int OFS_W = $clog2(LINE_BYTES);
  l1d_refill_state_e state;
  logic [31:0] addr;
  logic req, kill, hit, hit_way, victim, start;
  logic unused_ofs;
  assign req = load_ck_hit_req.load_req;
  assign kill = load_ck_hit_req.load_kill;
  assign addr = load_ck_hit_req.load_addr;
  assign unused_ofs = ^addr[OFS_W-1:0];
  assign load_hit_resp = '{load_hit: req && hit, load_miss: req && !hit};
  assign load_hit_way = hit_way;
  assign start = state == IDLE && req && !hit && !kill;
  assign refill_req_valid = state == REQ;
  l1d_tag_array #(.SETS(SETS), .TAG_W(TAG_W)) u_tags (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_idx     (addr[OFS_W +: IDX_W]),
    .rd_tag     (addr[31 -: TAG_W]),
    .hit        (hit),
    .hit_way    (hit_way),
    .victim_way (victim),
    .lru_en     (req && !kill && hit),
    .lru_way    (hit_way),
    .inv_all    (invalidate_all),
    .wr_en      (state == FILL && !invalidate_all),
    .wr_idx     (refill_req_addr[OFS_W +: IDX_W]),
    .wr_way     (refill_req_way),
    .wr_tag     (refill_req_addr[31 -: TAG_W])
  );
  // refill sequencer; the latched line address also supplies the fill index and tag
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      refill_req_addr <= '0;
      refill_req_way <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= REQ;
          refill_req_addr <= {addr[31:OFS_W], {OFS_W{1'b0}}};
          refill_req_way <= victim;
        end
        REQ: state <= refill_req_ready ? WAIT : kill ? IDLE : REQ;
        WAIT: if (refill_done) state <= FILL;
        default: state <= IDLE;
      endcase
    end
`ifdef LOAD_HIT_PERF_CNT_EN
  logic [31:0] hit_cnt, miss_cnt;
  // saturating event counters, cleared only by reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hit_cnt <= '0;
      miss_cnt <= '0;
    end else begin
      if (req && hit && !kill) hit_cnt <= sat_inc(hit_cnt);
      if (start) miss_cnt <= sat_inc(miss_cnt);
    end
  assign perf_hit_cnt = hit_cnt;
  assign perf_miss_cnt = miss_cnt;
`else
  assign perf_hit_cnt = '0;
  assign perf_miss_cnt = '0;
`endif
endmodule

// File: tb/tb_l1d_load_hit_checker.sv
// tb_l1d_load_hit_checker: directed stimulus checked against a behavioural cache model
module tb_l1d_load_hit_checker;
  import l1d_load_hit_checker_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0;
  logic rq = 1'b0, kl = 1'b0, rdy = 1'b0, dn = 1'b0, iv = 1'b0;
  logic [31:0] ad = '0;
  core_load_ck_hit_req_t req_s;
  core_load_hit_resp_t resp;
  logic way, rv, rw;
  logic [31:0] ra, phc, pmc;
  int checks = 0, failures = 0;
  bit armed = 0;
  assign req_s = '{load_req: rq, load_kill: kl, load_addr: ad};
  always #5 clk = ~clk;

  l1d_load_hit_checker dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .load_ck_hit_req  (req_s),
    .load_hit_resp    (resp),
    .load_hit_way     (way),
    .refill_req_valid (rv),
    .refill_req_ready (rdy),
    .refill_req_addr  (ra),
    .refill_req_way   (rw),
    .refill_done      (dn),
    .invalidate_all   (iv),
    .perf_hit_cnt     (phc),
    .perf_miss_cnt    (pmc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: cache contents per (way,set), LRU way per set, refill phase 0 idle 1 request 2 wait 3 fill
  logic [21:0] mt [2][64];
  bit mv [2][64];
  bit ml [64];
  int phase = 0, mhits = 0, mmiss = 0;
  logic [31:0] maddr = '0;
  bit mway = 0;

  function automatic int set_of(input logic [31:0] a);
    return int'((a >> 4) & 32'd63);
  endfunction

  function automatic bit look(input logic [31:0] a, output bit w);
    int s;
    s = set_of(a);
    w = 1'b0;
    if (mv[0][s] && mt[0][s] == 22'(a >> 10)) return 1'b1;
    w = 1'b1;
    if (mv[1][s] && mt[1][s] == 22'(a >> 10)) return 1'b1;
    w = 1'b0;
    return 1'b0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit h, w;
    int s, fs;
    if (!rst_n) begin
      foreach (mv[k, j]) mv[k][j] = 1'b0;
      foreach (ml[j]) ml[j] = 1'b0;
      phase = 0; maddr = '0; mway = 1'b0; mhits = 0; mmiss = 0;
    end else begin
      h = look(ad, w);
      s = set_of(ad);
      if (rq && !kl && h) begin
        ml[s] = !w;
        mhits++;
      end
      if (phase == 0) begin
        if (rq && !h && !kl) begin
          maddr = ad & ~32'hF;
          mway = !mv[0][s] ? 1'b0 : !mv[1][s] ? 1'b1 : ml[s];
          phase = 1;
          mmiss++;
        end
      end else if (phase == 1) phase = rdy ? 2 : kl ? 0 : 1;
      else if (phase == 2) begin
        if (dn) phase = 3;
      end else begin
        fs = set_of(maddr);
        if (!iv) begin
          mt[mway][fs] = 22'(maddr >> 10);
          mv[mway][fs] = 1'b1;
          ml[fs] = !mway;
        end
        phase = 0;
      end
      if (iv) foreach (mv[k, j]) mv[k][j] = 1'b0;
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk) if (armed) begin
    bit h, w;
    int eh, em;
    h = look(ad, w);
`ifdef LOAD_HIT_PERF_CNT_EN
    eh = mhits; em = mmiss;
`else
    eh = 0; em = 0;
`endif
    chk("hit", {31'b0, resp.load_hit}, {31'b0, rq && h});
    chk("miss", {31'b0, resp.load_miss}, {31'b0, rq && !h});
    if (rq && h) chk("hit_way", {31'b0, way}, {31'b0, w});
    chk("req_valid", {31'b0, rv}, {31'b0, phase == 1});
    chk("req_addr", ra, maddr);
    chk("req_way", {31'b0, rw}, {31'b0, mway});
    chk("perf_hit", phc, eh);
    chk("perf_miss", pmc, em);
  end

  task automatic drive(input logic r, input logic k, input logic [31:0] a,
                       input logic y, input logic d, input logic i);
    @(posedge clk);
    #1;
    rq = r; kl = k; ad = a; rdy = y; dn = d; iv = i;
    @(negedge clk);
  endtask

  task automatic refill(input logic [31:0] a, input logic ew, input logic inv);
    drive(1, 0, a, 0, 0, 0);
    chk("lit_start_miss", {31'b0, resp.load_miss}, 1);
    drive(0, 0, 0, 1, 0, 0);
    chk("lit_req_valid", {31'b0, rv}, 1);
    chk("lit_req_addr", ra, a & ~32'hF);
    chk("lit_req_way", {31'b0, rw}, {31'b0, ew});
    drive(0, 0, 0, 0, 1, 0);
    chk("lit_valid_drop", {31'b0, rv}, 0);
    drive(0, 0, 0, 0, 0, inv);
  endtask

  initial begin
    @(posedge clk);
    #1 armed = 1;
    @(posedge clk);
    @(negedge clk);
    chk("lit_rst_valid", {31'b0, rv}, 0);
    chk("lit_rst_addr", ra, 0);
    chk("lit_rst_phc", phc, 0);
    chk("lit_rst_pmc", pmc, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    // first miss, refill with ready at T+1 and done at T+2, hit at T+4
    refill(32'h0000_1230, 1'b0, 1'b0);
    drive(1, 0, 32'h0000_1230, 0, 0, 0);
    chk("lit_t4_hit", {31'b0, resp.load_hit}, 1);
    chk("lit_t4_way", {31'b0, way}, 0);
    // second way of set 0x23, then LRU picks way 1 for a third tag
    refill(32'h0000_1630, 1'b1, 1'b0);
    drive(1, 0, 32'h0000_1630, 0, 0, 0);
    chk("lit_w1_way", {31'b0, way}, 1);
    drive(1, 0, 32'h0000_1230, 0, 0, 0);
    chk("lit_w0_way", {31'b0, way}, 0);
    refill(32'h0000_1A30, 1'b1, 1'b0);
    drive(1, 1, 32'h0000_1630, 0, 0, 0);
    chk("lit_evicted_miss", {31'b0, resp.load_miss}, 1);
    // kill on the miss cycle, then kill during the request
    drive(1, 1, 32'h0000_4000, 0, 0, 0);
    chk("lit_kill_miss", {31'b0, resp.load_miss}, 1);
    drive(0, 0, 0, 0, 0, 0);
    chk("lit_kill_noreq", {31'b0, rv}, 0);
    drive(1, 0, 32'h0000_4000, 0, 0, 0);
    drive(1, 1, 32'h0000_4000, 0, 0, 0);
    chk("lit_kill_req_valid", {31'b0, rv}, 1);
    drive(0, 0, 0, 0, 0, 0);
    chk("lit_abandon", {31'b0, rv}, 0);
    // hit-under-miss while waiting for the refill
    drive(1, 0, 32'h0000_2000, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    drive(1, 0, 32'h0000_1230, 0, 0, 0);
    chk("lit_wait_hit", {31'b0, resp.load_hit}, 1);
    drive(1, 0, 32'h0000_8000, 0, 0, 0);
    chk("lit_wait_miss", {31'b0, resp.load_miss}, 1);
    chk("lit_wait_noreq", {31'b0, rv}, 0);
    drive(0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("lit_no_second_req", {31'b0, rv}, 0);
    // invalidate coincident with the fill
    refill(32'h0000_3000, 1'b1, 1'b1);
    drive(1, 1, 32'h0000_3000, 0, 0, 0);
    chk("lit_inv_fill_miss", {31'b0, resp.load_miss}, 1);
    drive(1, 1, 32'h0000_1230, 0, 0, 0);
    chk("lit_inv_all_miss", {31'b0, resp.load_miss}, 1);
    // reset in the middle of a refill, stray done afterwards
    drive(1, 0, 32'h0000_1230, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("lit_midrst_valid", {31'b0, rv}, 0);
    chk("lit_midrst_addr", ra, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(0, 0, 0, 0, 1, 0);
    drive(1, 1, 32'h0000_1230, 0, 0, 0);
    chk("lit_stray_done_miss", {31'b0, resp.load_miss}, 1);
    chk("lit_stray_done_noreq", {31'b0, rv}, 0);
    // two refills and three counted hits since reset
    refill(32'h0000_1230, 1'b0, 1'b0);
    refill(32'h0000_5000, 1'b0, 1'b0);
    drive(1, 0, 32'h0000_1230, 0, 0, 0);
    drive(1, 0, 32'h0000_1230, 0, 0, 0);
    drive(1, 1, 32'h0000_5000, 0, 0, 0);
    drive(1, 0, 32'h0000_5000, 0, 0, 0);
    chk("lit_set0_way", {31'b0, way}, 0);
    drive(0, 0, 0, 0, 0, 0);
`ifdef LOAD_HIT_PERF_CNT_EN
    chk("lit_perf_hit", phc, 3);
    chk("lit_perf_miss", pmc, 2);
`else
    chk("lit_perf_hit", phc, 0);
    chk("lit_perf_miss", pmc, 0);
`endif
    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
